dvp_pattern_tx: RTL and testbench

Transmit-side counterpart of the OV5640 DVP capture path. It generates an OV5640-style parallel camera stream (`cam_pclk`, `cam_vsync`, `cam_href`, 8-bit `cam_data`, RGB565 high byte first) from internal test patterns. It drives `ov5640_reader` in simulation and on board in place of a sensor, so capture, the frame tick and the HDMI path can be brought up without a camera. It runs entirely in one clock domain, and `cam_pclk` is derived as `clk/2`.

---
 rtl/dvp_pattern_tx.sv | 191 +++++++++++++++++++
 tb/tb_dvp_pattern_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pattern_tx.sv
// OV5640-style DVP stream generator: drives pclk/vsync/href/data from internal
// test patterns so the capture path can be exercised without a sensor.
module dvp_pattern_tx #(
    parameter int H_ACT   = 1280,
    parameter int H_BLANK = 160,
    parameter int V_SYNC  = 5,
    parameter int V_BP    = 20,
    parameter int V_ACT   = 720,
    parameter int V_FP    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pat_sel,
    input  logic [15:0] solid_rgb,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic        busy
);

    localparam int L   = 2 * H_ACT + H_BLANK;
    localparam int VT  = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HW  = $clog2(L + 1);
    localparam int VW  = $clog2(VT + 1);
    localparam int BW  = H_ACT / 8;
    localparam int BCW = $clog2(BW + 1);

    localparam logic [HW-1:0]  H_LAST      = HW'(L - 1);
    localparam logic [HW-1:0]  H_ACT_SLOTS = HW'(2 * H_ACT);
    localparam logic [VW-1:0]  V_LAST      = VW'(VT - 1);
    localparam logic [VW-1:0]  V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0]  V_ACT_START = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0]  V_ACT_END   = VW'(V_SYNC + V_BP + V_ACT);
    localparam logic [BCW-1:0] BAR_LAST    = BCW'(BW - 1);

    generate
        if (H_ACT <= 0 || (H_ACT % 8) != 0) begin : g_bad_h_act
            $error("dvp_pattern_tx: H_ACT must be a nonzero multiple of 8");
        end
    endgenerate

    logic            ph_q, ph_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    logic [BCW-1:0]  bar_cnt_q, bar_cnt_d;
    logic            fen_q, fen_d;
    logic [1:0]      psel_q, psel_d;
    logic [15:0]     solid_q, solid_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            pclk_q, pclk_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      data_q, data_d;
    logic            fstart_q, fstart_d;

    logic            boundary;
    logic            fen_e;
    logic [1:0]      psel_e;
    logic [15:0]     solid_e;
    logic [4:0]      fc5_e;
    logic [4:0]      x5;
    logic [5:0]      y6;
    logic [15:0]     bar_rgb;
    logic [15:0]     pixel;
    logic            href_e;

    // At the boundary edge the freshly sampled frame settings already govern slot 0.
    always_comb begin
        boundary = !ph_q && (hcnt_q == '0) && (vcnt_q == '0);
        fen_e    = boundary ? en : fen_q;
        psel_e   = boundary ? pat_sel : psel_q;
        solid_e  = boundary ? solid_rgb : solid_q;
        fc5_e    = (boundary && fen_q) ? frame_cnt_q[4:0] + 5'd1 : frame_cnt_q[4:0];
        x5       = 5'(hcnt_q >> 1);
        y6       = 6'(vcnt_q - V_ACT_START);
        href_e   = fen_e && (vcnt_q >= V_ACT_START) && (vcnt_q < V_ACT_END)
                   && (hcnt_q < H_ACT_SLOTS);

        case (bar_idx_q)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase

        case (psel_e)
            2'd1:    pixel = {x5, y6, fc5_e};
            2'd2:    pixel = solid_e;
            default: pixel = bar_rgb;
        endcase
    end

    // Counters advance at the end of each slot; outputs only change on the pclk falling edge.
    always_comb begin
        ph_d        = ~ph_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        bar_idx_d   = bar_idx_q;
        bar_cnt_d   = bar_cnt_q;
        fen_d       = fen_e;
        psel_d      = psel_e;
        solid_d     = solid_e;
        frame_cnt_d = frame_cnt_q;
        pclk_d      = ph_q;
        fstart_d    = 1'b0;
        vsync_d     = vsync_q;
        href_d      = href_q;
        data_d      = data_q;

        if (ph_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d    = '0;
                bar_idx_d = '0;
                bar_cnt_d = '0;
                vcnt_d    = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
                if (hcnt_q[0] && (hcnt_q < H_ACT_SLOTS)) begin
                    if (bar_cnt_q == BAR_LAST) begin
                        bar_cnt_d = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + 1'b1;
                    end
                end
            end
        end else begin
            vsync_d = fen_e && (vcnt_q < V_SYNC_END);
            href_d  = href_e;
            data_d  = href_e ? (hcnt_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
            if (boundary) begin
                fstart_d = en;
                if (fen_q) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q        <= 1'b0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            bar_idx_q   <= '0;
            bar_cnt_q   <= '0;
            fen_q       <= 1'b0;
            psel_q      <= '0;
            solid_q     <= '0;
            frame_cnt_q <= '0;
            pclk_q      <= 1'b1;
            fstart_q    <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            ph_q        <= ph_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            bar_idx_q   <= bar_idx_d;
            bar_cnt_q   <= bar_cnt_d;
            fen_q       <= fen_d;
            psel_q      <= psel_d;
            solid_q     <= solid_d;
            frame_cnt_q <= frame_cnt_d;
            pclk_q      <= pclk_d;
            fstart_q    <= fstart_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
        end
    end

    assign cam_pclk    = pclk_q;
    assign cam_vsync   = vsync_q;
    assign cam_href    = href_q;
    assign cam_data    = data_q;
    assign frame_start = fstart_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = fen_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Bench for dvp_pattern_tx: a frame-arithmetic reference model feeds a scoreboard
// queue that a negedge monitor drains, plus directed checks at key edges.
module tb_dvp_pattern_tx;

    localparam int H_ACT   = 16;
    localparam int H_BLANK = 4;
    localparam int V_SYNC  = 1;
    localparam int V_BP    = 1;
    localparam int V_ACT   = 3;
    localparam int V_FP    = 1;
    localparam int L         = 2 * H_ACT + H_BLANK;
    localparam int VT        = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int FRAME_CLK = 2 * L * VT;

    typedef struct {
        int         edgeIdx;
        logic       pclk;
        logic       vsync;
        logic       href;
        logic [7:0] data;
        logic       fs;
        logic [7:0] fc;
        logic       busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        cam_pclk, cam_vsync, cam_href, frame_start, busy;
    logic [7:0]  cam_data, frame_cnt;

    int checks = 0;
    int errors = 0;
    int edgeNum = 0;
    int hrefCycles = 0;
    exp_t expQ[$];

    int          mT = 0;
    logic        mEn = 1'b0;
    logic [1:0]  mPsel = 2'd0;
    logic [15:0] mSolid = 16'h0000;
    int          mFc = 0;
    int          mPos, mLine, mS, mX, mY, mPix;
    logic [15:0] barColor [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                  16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    dvp_pattern_tx #(
        .H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_SYNC(V_SYNC),
        .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .frame_start(frame_start), .frame_cnt(frame_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) edgeNum = 0;
        else edgeNum++;
    end

    // Reference: everything derives from the edge index since reset release.
    always @(posedge clk) begin
        exp_t e;
        e.edgeIdx = mT;
        if (rst) begin
            mT = 0; mEn = 1'b0; mPsel = 2'd0; mSolid = 16'h0; mFc = 0;
            e.pclk = 1'b1; e.vsync = 1'b0; e.href = 1'b0; e.data = 8'h00;
            e.fs = 1'b0; e.fc = 8'h00; e.busy = 1'b0;
        end else begin
            if (mT % FRAME_CLK == 0) begin
                if (mEn) mFc = (mFc + 1) % 256;
                mEn = en; mPsel = pat_sel; mSolid = solid_rgb;
                e.fs = en;
            end else begin
                e.fs = 1'b0;
            end
            mPos  = (mT % FRAME_CLK) / 2;
            mLine = mPos / L;
            mS    = mPos % L;
            mX    = mS / 2;
            mY    = mLine - V_SYNC - V_BP;
            e.pclk  = (mT % 2) == 1;
            e.vsync = mEn && (mLine < V_SYNC);
            e.href  = mEn && (mLine >= V_SYNC + V_BP) && (mLine < V_SYNC + V_BP + V_ACT)
                      && (mS < 2 * H_ACT);
            if (mPsel == 2'd1)      mPix = ((mX % 32) * 2048) + ((mY % 64) * 32) + (mFc % 32);
            else if (mPsel == 2'd2) mPix = int'(mSolid);
            else                    mPix = int'(barColor[mX / (H_ACT / 8)]);
            e.data = !e.href ? 8'h00 : ((mS % 2 == 0) ? 8'(mPix / 256) : 8'(mPix % 256));
            e.busy = mEn;
            e.fc   = 8'(mFc);
            mT++;
        end
        expQ.push_back(e);
    end

    // Monitor: one expected record per edge, compared away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (cam_pclk !== e.pclk || cam_vsync !== e.vsync || cam_href !== e.href ||
                cam_data !== e.data || frame_start !== e.fs || frame_cnt !== e.fc ||
                busy !== e.busy) begin
                errors++;
                $display("[TB] FAIL scoreboard edge %0d: got pclk=%0b vs=%0b href=%0b data=%02h fs=%0b fc=%0d busy=%0b, expected pclk=%0b vs=%0b href=%0b data=%02h fs=%0b fc=%0d busy=%0b",
                         e.edgeIdx, cam_pclk, cam_vsync, cam_href, cam_data, frame_start,
                         frame_cnt, busy, e.pclk, e.vsync, e.href, e.data, e.fs, e.fc, e.busy);
            end
            if (cam_href === 1'b1) hrefCycles++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Returns just after edge e has been applied (at the following negedge).
    task automatic stepTo(input int e);
        int guard = 0;
        while (edgeNum < e + 1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (edgeNum < e + 1) begin
            errors++;
            $display("[TB] FAIL stepTo timeout: edge %0d, expected %0d", edgeNum, e + 1);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset pclk", int'(cam_pclk), 1);
        checkOutput("reset vsync", int'(cam_vsync), 0);
        checkOutput("reset href", int'(cam_href), 0);
        checkOutput("reset data", int'(cam_data), 0);
        checkOutput("reset frame_start", int'(frame_start), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        hrefCycles = 0;
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) pat_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) solid_rgb = 16'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] start");

        en = 1'b1; pat_sel = 2'd0; solid_rgb = 16'h0000;
        doReset();
        stepTo(0);
        checkOutput("bars frame_start edge0", int'(frame_start), 1);
        checkOutput("bars vsync edge0", int'(cam_vsync), 1);
        checkOutput("bars busy edge0", int'(busy), 1);
        stepTo(1);
        checkOutput("bars frame_start edge1", int'(frame_start), 0);
        stepTo(71);
        checkOutput("bars vsync edge71", int'(cam_vsync), 1);
        stepTo(72);
        checkOutput("bars vsync edge72", int'(cam_vsync), 0);
        stepTo(143);
        checkOutput("bars href edge143", int'(cam_href), 0);
        stepTo(144);
        checkOutput("bars href edge144", int'(cam_href), 1);
        checkOutput("bars data edge144", int'(cam_data), 'hFF);
        stepTo(154);
        checkOutput("bars data edge154", int'(cam_data), 'hE0);
        stepTo(300);
        pat_sel = 2'd1;
        stepTo(431);
        checkOutput("frame_cnt edge431", int'(frame_cnt), 0);
        stepTo(432);
        checkOutput("frame_cnt edge432", int'(frame_cnt), 1);
        stepTo(660);
        checkOutput("gradient hi byte", int'(cam_data), 'h18);
        stepTo(662);
        checkOutput("gradient lo byte", int'(cam_data), 'h21);

        en = 1'b1; pat_sel = 2'd0;
        doReset();
        stepTo(199);
        en = 1'b0;
        stepTo(431);
        checkOutput("en drop href cycles", hrefCycles, 3 * 32 * 2);
        stepTo(432);
        checkOutput("disabled vsync", int'(cam_vsync), 0);
        checkOutput("disabled frame_start", int'(frame_start), 0);
        checkOutput("disabled busy", int'(busy), 0);
        checkOutput("disabled frame_cnt", int'(frame_cnt), 1);
        stepTo(576);
        checkOutput("disabled href", int'(cam_href), 0);
        stepTo(864);
        checkOutput("disabled frame_cnt hold", int'(frame_cnt), 1);

        en = 1'b1; pat_sel = 2'd0; solid_rgb = 16'h0000;
        doReset();
        stepTo(299);
        pat_sel = 2'd2; solid_rgb = 16'hABCD;
        stepTo(302);
        checkOutput("solid change ignored mid-frame", int'(cam_data), 'hE0);
        stepTo(576);
        checkOutput("solid hi byte", int'(cam_data), 'hAB);
        stepTo(578);
        checkOutput("solid lo byte", int'(cam_data), 'hCD);

        en = 1'b1; pat_sel = 2'd0;
        doReset();
        stepTo(169);
        checkOutput("pre-reset href", int'(cam_href), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset href", int'(cam_href), 0);
        checkOutput("mid reset data", int'(cam_data), 0);
        checkOutput("mid reset pclk", int'(cam_pclk), 1);
        rst = 1'b0;
        stepTo(0);
        checkOutput("restart vsync", int'(cam_vsync), 1);
        checkOutput("restart frame_cnt", int'(frame_cnt), 0);

        applyStimulus(4000);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
